// File: rtl/regfile_writeback.sv
// Register-file writeback stage: ALU, link and formatted load results, one in flight at a time.
// Build option: define REGFILE_WB_FORWARD_EN to forward the WRITE-cycle value to the decode stage.
module regfile_writeback (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [1:0]  in_wb_sel,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_pc,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_byte_off,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        RegWrite,
  output logic [4:0]  rd,
  output logic [31:0] write_data,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        hazard1,
  output logic        hazard2,
  output logic        fwd_valid1,
  output logic        fwd_valid2,
  output logic [31:0] fwd_data1,
  output logic [31:0] fwd_data2
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  state_t      state_q, state_d;
  logic        pend_valid_q, pend_valid_d;
  logic [4:0]  pend_rd_q, pend_rd_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;

  function automatic logic [31:0] load_format(input logic [2:0] f3,
                                              input logic [1:0] off,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_format = {{24{b[7]}}, b};
      3'b100:  load_format = {24'd0, b};
      3'b001:  load_format = {{16{h[15]}}, h};
      3'b101:  load_format = {16'd0, h};
      default: load_format = w;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_rd_d    = pend_rd_q;
    rd_d         = rd_q;
    wdata_d      = wdata_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          case (in_wb_sel)
            SEL_ALU, SEL_LINK: begin
              if (in_rd != 5'd0) begin
                rd_d         = in_rd;
                wdata_d      = (in_wb_sel == SEL_ALU) ? in_alu_result : in_pc + 32'd4;
                pend_valid_d = 1'b1;
                pend_rd_d    = in_rd;
                state_d      = WRITE;
              end
            end
            SEL_LOAD: begin
              // A load to x0 still has to consume its memory response.
              rd_d         = in_rd;
              funct3_d     = in_funct3;
              off_d        = in_byte_off;
              pend_valid_d = (in_rd != 5'd0);
              pend_rd_d    = in_rd;
              state_d      = WAIT_MEM;
            end
            default: ;
          endcase
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          if (rd_q != 5'd0) begin
            wdata_d = load_format(funct3_q, off_q, mem_rdata);
            state_d = WRITE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WRITE: begin
        pend_valid_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pend_valid_q <= 1'b0;
      pend_rd_q    <= 5'd0;
      rd_q         <= 5'd0;
      wdata_q      <= 32'd0;
      funct3_q     <= 3'd0;
      off_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_rd_q    <= pend_rd_d;
      rd_q         <= rd_d;
      wdata_q      <= wdata_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign RegWrite   = (state_q == WRITE);
  assign rd         = rd_q;
  assign write_data = wdata_q;

  logic pend_hit1, pend_hit2;
  assign pend_hit1 = pend_valid_q && (rs1 != 5'd0) && (pend_rd_q == rs1);
  assign pend_hit2 = pend_valid_q && (rs2 != 5'd0) && (pend_rd_q == rs2);

`ifdef REGFILE_WB_FORWARD_EN
  assign fwd_valid1 = (state_q == WRITE) && (rs1 != 5'd0) && (rs1 == rd_q);
  assign fwd_valid2 = (state_q == WRITE) && (rs2 != 5'd0) && (rs2 == rd_q);
  assign fwd_data1  = fwd_valid1 ? wdata_q : 32'd0;
  assign fwd_data2  = fwd_valid2 ? wdata_q : 32'd0;
  assign hazard1    = pend_hit1 && !fwd_valid1;
  assign hazard2    = pend_hit2 && !fwd_valid2;
`else
  assign fwd_valid1 = 1'b0;
  assign fwd_valid2 = 1'b0;
  assign fwd_data1  = 32'd0;
  assign fwd_data2  = 32'd0;
  assign hazard1    = pend_hit1;
  assign hazard2    = pend_hit2;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized bench for regfile_writeback, checked against a transaction-level reference.
module tb_regfile_writeback;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc;
  logic [2:0]  in_funct3;
  logic [1:0]  in_byte_off;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic [4:0]  rs1, rs2;
  logic        hazard1, hazard2;
  logic        fwd_valid1, fwd_valid2;
  logic [31:0] fwd_data1, fwd_data2;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_writeback dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_wb_sel(in_wb_sel),
    .in_alu_result(in_alu_result), .in_pc(in_pc), .in_funct3(in_funct3),
    .in_byte_off(in_byte_off), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .RegWrite(RegWrite), .rd(rd), .write_data(write_data),
    .rs1(rs1), .rs2(rs2), .hazard1(hazard1), .hazard2(hazard2),
    .fwd_valid1(fwd_valid1), .fwd_valid2(fwd_valid2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * int'(off))) & 32'h0000_00FF;
    h = (w >> (16 * int'(off[1]))) & 32'h0000_FFFF;
    case (f3)
      3'd0:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
  task automatic do_txn(input logic [1:0] sel, input logic [4:0] r, input logic [31:0] alu,
                        input logic [31:0] pc, input logic [2:0] f3, input logic [1:0] off,
                        input logic [31:0] rdata, input int dly);
    logic [31:0] exp;
    logic        wr;
    logic [4:0]  s2;
    s2 = 5'($urandom_range(0, 31));
    chk("idle_ready", in_ready, 1);
    chk("idle_haz1", hazard1, 0);
    in_valid = 1'b1; in_rd = r; in_wb_sel = sel; in_alu_result = alu; in_pc = pc;
    in_funct3 = f3; in_byte_off = off; rs1 = r; rs2 = s2;
    @(negedge clock);
    in_valid = 1'b0;
    if (sel == 2'd1) begin
      wr  = (r != 0);
      exp = ref_load(f3, off, rdata);
      for (int i = 0; i <= dly; i++) begin
        chk("wait_ready", in_ready, 0);
        chk("wait_regwrite", RegWrite, 0);
        chk("wait_haz1", hazard1, wr);
        chk("wait_haz2", hazard2, wr && s2 == r);
        in_valid = 1'b1; in_wb_sel = 2'd0; in_rd = 5'd17; in_alu_result = 32'hDEAD_BEEF;
        if (i == dly) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rdata;
        end
        @(negedge clock);
      end
      mem_rvalid = 1'b0;
      in_valid   = 1'b0;
      mem_rdata  = $urandom;
    end else begin
      wr  = (sel != 2'd3) && (r != 0);
      exp = (sel == 2'd0) ? alu : pc + 32'd4;
    end
    chk("regwrite", RegWrite, wr);
    if (wr) begin
      chk("wr_rd", rd, r);
      chk("wr_data", write_data, exp);
      chk("wr_ready", in_ready, 0);
`ifdef REGFILE_WB_FORWARD_EN
      chk("wr_haz1", hazard1, 0);
      chk("wr_fwdv1", fwd_valid1, 1);
      chk("wr_fwdd1", fwd_data1, exp);
      chk("wr_haz2", hazard2, 0);
      chk("wr_fwdv2", fwd_valid2, s2 == r);
      chk("wr_fwdd2", fwd_data2, (s2 == r) ? exp : 32'd0);
`else
      chk("wr_haz1", hazard1, 1);
      chk("wr_fwdv1", fwd_valid1, 0);
      chk("wr_fwdd1", fwd_data1, 0);
      chk("wr_haz2", hazard2, s2 == r);
`endif
      @(negedge clock);
      chk("post_regwrite", RegWrite, 0);
    end else begin
      chk("nowr_haz1", hazard1, 0);
    end
    chk("post_ready", in_ready, 1);
    chk("post_haz1", hazard1, 0);
  endtask

  initial begin
    logic [1:0] sel;
    logic [4:0] r;
    reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_wb_sel = '0; in_alu_result = '0;
    in_pc = '0; in_funct3 = '0; in_byte_off = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    rs1 = '0; rs2 = '0;
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_rd", rd, 0);
    chk("rst_wdata", write_data, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    do_txn(2'd0, 5'd5, 32'h1234_5678, 32'h0, 3'd0, 2'd0, 32'h0, 0);
    do_txn(2'd1, 5'd7, 32'h0, 32'h0, 3'b000, 2'd2, 32'h0080_0000, 1);
    do_txn(2'd1, 5'd8, 32'h0, 32'h0, 3'b101, 2'd2, 32'h8001_0000, 0);
    do_txn(2'd2, 5'd1, 32'h0, 32'hFFFF_FFFC, 3'd0, 2'd0, 32'h0, 0);
    do_txn(2'd0, 5'd0, 32'hAAAA_5555, 32'h0, 3'd0, 2'd0, 32'h0, 0);
    do_txn(2'd3, 5'd3, 32'h5555_AAAA, 32'h0, 3'd0, 2'd0, 32'h0, 0);
    do_txn(2'd1, 5'd9, 32'h0, 32'h0, 3'b010, 2'd1, 32'hCAFE_F00D, 3);
    do_txn(2'd1, 5'd0, 32'h0, 32'h0, 3'b010, 2'd0, 32'h1111_2222, 2);

    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        mem_rvalid = 1'b1; mem_rdata = $urandom;
        @(negedge clock);
        mem_rvalid = 1'b0;
        chk("stray_rvalid_wr", RegWrite, 0);
        chk("stray_rvalid_ready", in_ready, 1);
      end
      sel = 2'($urandom_range(0, 3));
      r   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      do_txn(sel, r, $urandom, $urandom, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
             $urandom, $urandom_range(0, 3));
    end

    in_valid = 1'b1; in_wb_sel = 2'd1; in_rd = 5'd9; in_funct3 = 3'd2; rs1 = 5'd9; rs2 = 5'd9;
    @(negedge clock);
    in_valid = 1'b0;
    chk("rst_pre_haz1", hazard1, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_regwrite", RegWrite, 0);
    chk("rst_mid_rd", rd, 0);
    chk("rst_mid_wdata", write_data, 0);
    chk("rst_mid_haz1", hazard1, 0);
    chk("rst_mid_fwdv1", fwd_valid1, 0);
    chk("rst_mid_fwdd1", fwd_data1, 0);
    chk("rst_mid_ready", in_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_ABCD;
    @(negedge clock);
    mem_rvalid = 1'b0;
    chk("rst_post_regwrite", RegWrite, 0);
    chk("rst_post_haz1", hazard1, 0);
    chk("rst_post_ready", in_ready, 1);
    @(negedge clock);
    chk("rst_post2_regwrite", RegWrite, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
